// File: rtl/blockmem_2p_arbiter.sv
// Two-requester write/read arbiter and response sequencer for a simple dual-port block RAM
// (port A write, port B read with one-cycle registered output), both ports on one clock.

module blockmem_2p_arbiter_rsp #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          grant,
  input  logic          rready,
  input  logic [DW-1:0] doutb,
  output logic          pend,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend   <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      pend <= grant;
      // doutb belongs to the read issued last cycle; it lands in the one-entry buffer
      if (pend) begin
        rvalid <= 1'b1;
        rdata  <= doutb;
      end else if (rready) begin
        rvalid <= 1'b0;
      end
    end
  end
endmodule

module blockmem_2p_arbiter #(
  parameter  int G_DATAWIDTH = 32,
  parameter  int G_MEMDEPTH  = 1024,
  parameter  int G_BWENABLE  = 0,
  localparam int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  localparam int G_WEWIDTH   = (((G_DATAWIDTH + 7) / 8 - 1) * G_BWENABLE) + 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr0_valid,
  output logic                   wr0_ready,
  input  logic [G_ADDRWIDTH-1:0] wr0_addr,
  input  logic [G_DATAWIDTH-1:0] wr0_data,
  input  logic [G_WEWIDTH-1:0]   wr0_strb,
  input  logic                   wr1_valid,
  output logic                   wr1_ready,
  input  logic [G_ADDRWIDTH-1:0] wr1_addr,
  input  logic [G_DATAWIDTH-1:0] wr1_data,
  input  logic [G_WEWIDTH-1:0]   wr1_strb,
  input  logic                   rd0_valid,
  output logic                   rd0_ready,
  input  logic [G_ADDRWIDTH-1:0] rd0_addr,
  output logic                   rd0_rvalid,
  input  logic                   rd0_rready,
  output logic [G_DATAWIDTH-1:0] rd0_rdata,
  input  logic                   rd1_valid,
  output logic                   rd1_ready,
  input  logic [G_ADDRWIDTH-1:0] rd1_addr,
  output logic                   rd1_rvalid,
  input  logic                   rd1_rready,
  output logic [G_DATAWIDTH-1:0] rd1_rdata,
  output logic                   mem_ena,
  output logic [G_WEWIDTH-1:0]   mem_wea,
  output logic [G_ADDRWIDTH-1:0] mem_addra,
  output logic [G_DATAWIDTH-1:0] mem_dina,
  output logic                   mem_enb,
  output logic [G_ADDRWIDTH-1:0] mem_addrb,
  input  logic [G_DATAWIDTH-1:0] mem_doutb
);
  logic [1:0]                  wr_v, wr_gnt, rd_v, rd_rr, rd_elig, rd_gnt, pend, rvalid;
  logic [1:0][G_ADDRWIDTH-1:0] wr_addr, rd_addr;
  logic [1:0][G_DATAWIDTH-1:0] wr_data, rdata;
  logic [1:0][G_WEWIDTH-1:0]   wr_strb;
  logic                        wr_pri, rd_pri, wr_sel, rd_sel;

  assign wr_v    = {wr1_valid, wr0_valid};
  assign wr_addr = {wr1_addr, wr0_addr};
  assign wr_data = {wr1_data, wr0_data};
  assign wr_strb = {wr1_strb, wr0_strb};
  assign rd_v    = {rd1_valid, rd0_valid};
  assign rd_addr = {rd1_addr, rd0_addr};
  assign rd_rr   = {rd1_rready, rd0_rready};

  always_comb begin
    wr_gnt = wr_v;
    if (&wr_v) begin
      wr_gnt         = '0;
      wr_gnt[wr_pri] = 1'b1;
    end
  end

  assign wr_sel    = wr_gnt[1];
  assign wr0_ready = wr_gnt[0];
  assign wr1_ready = wr_gnt[1];
  assign mem_ena   = |wr_gnt;
  assign mem_addra = mem_ena ? wr_addr[wr_sel] : '0;
  assign mem_dina  = mem_ena ? wr_data[wr_sel] : '0;
  assign mem_wea   = !mem_ena ? '0 : (G_BWENABLE != 0) ? wr_strb[wr_sel] : '1;

  // A read that hits this cycle's write address waits a cycle so it sees the new data
  always_comb begin
    for (int n = 0; n < 2; n++)
      rd_elig[n] = rd_v[n] & ~pend[n] & (~rvalid[n] | rd_rr[n])
                 & ~(mem_ena & (rd_addr[n] == mem_addra));
    rd_gnt = rd_elig;
    if (&rd_elig) begin
      rd_gnt         = '0;
      rd_gnt[rd_pri] = 1'b1;
    end
  end

  assign rd_sel    = rd_gnt[1];
  assign rd0_ready = rd_gnt[0];
  assign rd1_ready = rd_gnt[1];
  assign mem_enb   = |rd_gnt;
  assign mem_addrb = mem_enb ? rd_addr[rd_sel] : '0;

  for (genvar n = 0; n < 2; n++) begin : g_rsp
    blockmem_2p_arbiter_rsp #(.DW(G_DATAWIDTH)) u_rsp (
      .clk    (clk),
      .resetn (resetn),
      .grant  (rd_gnt[n]),
      .rready (rd_rr[n]),
      .doutb  (mem_doutb),
      .pend   (pend[n]),
      .rvalid (rvalid[n]),
      .rdata  (rdata[n])
    );
  end

  assign rd0_rvalid = rvalid[0];
  assign rd1_rvalid = rvalid[1];
  assign rd0_rdata  = rdata[0];
  assign rd1_rdata  = rdata[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_pri <= 1'b0;
      rd_pri <= 1'b0;
    end else begin
      if (mem_ena) wr_pri <= ~wr_sel;
      if (mem_enb) rd_pri <= ~rd_sel;
    end
  end
endmodule
